// File: rtl/spi_flash_pkg.sv
// Shared constants and state encoding for the SPI flash reader.
package spi_flash_pkg;

   localparam logic [7:0]  READ_CMD      = 8'h03;
   localparam int unsigned ADDR_W        = 24;
   localparam int unsigned CMD_ADDR_BITS = 32;
   localparam int unsigned DATA_BITS     = 32;
   localparam int unsigned TOTAL_BITS    = 64;
   localparam int unsigned CNT_W         = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/spi_bit_engine.sv
// Mode-0 SPI shifter: drives SCK/CS/MOSI, shifts out command+address, shifts in one data word.
module spi_bit_engine
   import spi_flash_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start_c,
   input  logic [ADDR_W-1:0]        addr,
   input  logic                     spi_in,
   output logic                     spi_clk,
   output logic                     spi_out,
   output logic                     spi_cs_n,
   output logic                     done_c,
   output logic [DATA_BITS-1:0]     rx_word
);

   state_e                     state_q, state_d;
   logic [CMD_ADDR_BITS-1:0]   tx_q, tx_d;
   logic [DATA_BITS-1:0]       rx_q, rx_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic                       sck_q, sck_d;
   logic                       mosi_q, mosi_d;
   logic                       cs_n_q, cs_n_d;

   // MOSI is registered one bit ahead so it is stable for the whole LOW cycle before each SCK rise.
   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      cnt_d   = cnt_q;
      sck_d   = sck_q;
      mosi_d  = mosi_q;
      cs_n_d  = cs_n_q;
      case (state_q)
         IDLE: begin
            if (start_c) begin
               tx_d    = {addr, READ_CMD};
               rx_d    = '0;
               cnt_d   = '0;
               cs_n_d  = 1'b0;
               mosi_d  = READ_CMD[0];
               state_d = LOW;
            end
         end
         LOW: begin
            sck_d   = 1'b1;
            state_d = HIGH;
         end
         HIGH: begin
            sck_d = 1'b0;
            tx_d  = tx_q >> 1;
            if (cnt_q >= CNT_W'(CMD_ADDR_BITS)) begin
               rx_d = {rx_q[DATA_BITS-2:0], spi_in};
            end
            cnt_d   = cnt_q + CNT_W'(1);
            mosi_d  = (cnt_q < CNT_W'(CMD_ADDR_BITS - 1)) ? tx_q[1] : 1'b0;
            state_d = (cnt_q == CNT_W'(TOTAL_BITS - 1)) ? DONE : LOW;
         end
         DONE: begin
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         tx_q    <= '0;
         rx_q    <= '0;
         cnt_q   <= '0;
         sck_q   <= 1'b0;
         mosi_q  <= 1'b0;
         cs_n_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         cnt_q   <= cnt_d;
         sck_q   <= sck_d;
         mosi_q  <= mosi_d;
         cs_n_q  <= cs_n_d;
      end
   end

   assign spi_clk  = sck_q;
   assign spi_out  = mosi_q;
   assign spi_cs_n = cs_n_q;
   assign done_c   = (state_q == DONE);
   assign rx_word  = rx_q;

endmodule

// File: rtl/spi_flash_reader.sv
// Read-only SPI NOR flash controller: valid/ready request in, one 32-bit word out per READ.
module spi_flash_reader
   import spi_flash_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   output logic                  spiOut,
   input  logic                  spiIn,
   output logic                  spiClk,
   output logic                  spiCs,
   input  logic [ADDR_W-1:0]     address,
   output logic [DATA_BITS-1:0]  data,
   output logic                  ready,
   input  logic                  valid
);

   logic                  ready_q, ready_d;
   logic [DATA_BITS-1:0]  data_q, data_d;
   logic                  start_c;
   logic                  done_c;
   logic [DATA_BITS-1:0]  rx_word;

   assign start_c = valid & ready_q;

   spi_bit_engine u_engine (
      .clk      (clk),
      .reset    (reset),
      .start_c  (start_c),
      .addr     (address),
      .spi_in   (spiIn),
      .spi_clk  (spiClk),
      .spi_out  (spiOut),
      .spi_cs_n (spiCs),
      .done_c   (done_c),
      .rx_word  (rx_word)
   );

   // Handshake and result register; data only changes when a transfer completes.
   always_comb begin
      ready_d = ready_q;
      data_d  = data_q;
      if (start_c) begin
         ready_d = 1'b0;
      end
      if (done_c) begin
         ready_d = 1'b1;
         data_d  = rx_word;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ready_q <= 1'b1;
         data_q  <= '0;
      end else begin
         ready_q <= ready_d;
         data_q  <= data_d;
      end
   end

   assign ready = ready_q;
   assign data  = data_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed + randomized bench for spi_flash_reader with a behavioural SPI flash model.
module tb_spi_flash_reader;

   logic        clk;
   logic        reset;
   logic        spiOut;
   logic        spiIn;
   logic        spiClk;
   logic        spiCs;
   logic [23:0] address;
   logic [31:0] data;
   logic        ready;
   logic        valid;

   int checks = 0;
   int errors = 0;

   // flash model state
   logic [31:0] flash_word = 32'h0;
   logic [63:0] mosi_cap   = 64'h0;
   int          rise_idx   = 0;
   logic        prev_sck   = 1'b0;

   spi_flash_reader dut (
      .clk     (clk),
      .reset   (reset),
      .spiOut  (spiOut),
      .spiIn   (spiIn),
      .spiClk  (spiClk),
      .spiCs   (spiCs),
      .address (address),
      .data    (data),
      .ready   (ready),
      .valid   (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Flash: on each observed SCK rise, record MOSI and present the next MISO bit (MSB first in bits 32-63).
   always @(negedge clk) begin
      if (spiCs !== 1'b0) begin
         rise_idx = 0;
         spiIn    = 1'b0;
      end else if (spiClk === 1'b1 && prev_sck === 1'b0) begin
         if (rise_idx < 64) mosi_cap[rise_idx] = spiOut;
         if (rise_idx >= 32 && rise_idx < 64) spiIn = flash_word[63 - rise_idx];
         else spiIn = 1'b0;
         rise_idx = rise_idx + 1;
      end
      prev_sck = spiClk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for idle, then present a request and check the acceptance edge.
   task automatic start_xfer(input logic [23:0] a, input logic [31:0] w, input bit hold);
      for (int i = 0; i < 300 && ready !== 1'b1; i++) begin
         @(posedge clk); #1;
      end
      check("idle_before_start", 64'(ready), 64'(1));
      address    = a;
      flash_word = w;
      valid      = 1'b1;
      @(posedge clk); #1;
      valid = hold;
      check("ready_low_after_accept", 64'(ready), 64'(0));
      check("cs_low_after_accept", 64'(spiCs), 64'(0));
      check("mosi_first_bit", 64'(spiOut), 64'(1));
   endtask

   // Run to completion and compare against the flash model's expectations.
   task automatic finish_xfer(input logic [23:0] a, input logic [31:0] w, input logic [31:0] prev,
                              input bit noise, input bit keep_valid);
      int n      = 0;
      int cs_low = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         n++;
         if (ready === 1'b1) break;
         if (spiCs === 1'b0) cs_low++;
         if (n == 64) check("data_held_mid_xfer", 64'(data), 64'(prev));
         if (noise) begin
            valid   = 1'($urandom);
            address = 24'($urandom);
         end
      end
      if (!keep_valid) valid = 1'b0;
      check("ready_latency", 64'(n), 64'(129));
      check("cs_low_cycles", 64'(cs_low), 64'(128));
      check("cs_released", 64'(spiCs), 64'(1));
      check("sck_idle", 64'(spiClk), 64'(0));
      check("data_word", 64'(data), 64'(w));
      check("sck_rises", 64'(rise_idx), 64'(64));
      check("mosi_stream", mosi_cap, {32'h0, a, 8'h03});
   endtask

   initial begin
      logic [23:0] ra;
      logic [31:0] rw;
      logic [31:0] last;
      reset   = 1'b1;
      valid   = 1'b0;
      address = 24'h0;
      @(posedge clk); #1;
      reset = 1'b0;
      check("rst_ready", 64'(ready), 64'(1));
      check("rst_cs", 64'(spiCs), 64'(1));
      check("rst_sck", 64'(spiClk), 64'(0));
      check("rst_mosi", 64'(spiOut), 64'(0));
      check("rst_data", 64'(data), 64'(0));

      // basic read
      start_xfer(24'hDEADFF, 32'h1ACFFC1D, 1'b0);
      finish_xfer(24'hDEADFF, 32'h1ACFFC1D, 32'h0, 1'b0, 1'b0);
      last = 32'h1ACFFC1D;

      // randomized reads, alternating with busy-time noise on valid/address
      for (int k = 0; k < 4; k++) begin
         ra = 24'($urandom);
         rw = $urandom;
         start_xfer(ra, rw, 1'b0);
         finish_xfer(ra, rw, last, k[0], 1'b0);
         last = rw;
      end

      // back-to-back with valid held high
      ra = 24'($urandom);
      rw = $urandom;
      start_xfer(ra, rw, 1'b1);
      finish_xfer(ra, rw, last, 1'b0, 1'b1);
      last    = rw;
      ra      = 24'($urandom);
      rw      = $urandom;
      address = ra;
      flash_word = rw;
      @(posedge clk); #1;
      valid = 1'b0;
      check("b2b_restart_ready", 64'(ready), 64'(0));
      check("b2b_restart_cs", 64'(spiCs), 64'(0));
      finish_xfer(ra, rw, last, 1'b0, 1'b0);

      // abort at bit 40
      start_xfer(24'h123456, 32'hCAFEF00D, 1'b0);
      for (int i = 0; i < 200 && rise_idx < 41; i++) begin
         @(posedge clk); #1;
      end
      check("abort_reached_bit40", 64'(rise_idx), 64'(41));
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_cs", 64'(spiCs), 64'(1));
      check("abort_sck", 64'(spiClk), 64'(0));
      check("abort_ready", 64'(ready), 64'(1));
      check("abort_mosi", 64'(spiOut), 64'(0));
      check("abort_data", 64'(data), 64'(0));
      start_xfer(24'h000000, 32'hFFFFFFFF, 1'b0);
      finish_xfer(24'h000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
